// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared definitions for the reset release sequencer: FSM
//               state encoding, index-width helper and a parameter-legality
//               check macro used by the top level.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef RST_SEQ_PKG_MACROS
`define RST_SEQ_PKG_MACROS
// Elaboration-time rejection of parameter sets the sequencer cannot honour:
// at least one domain, at least one hold cycle, and a hold counter wide
// enough to reach HOLD_CYCLES-1.
`define RST_SEQ_PARAM_CHECK(ND, HC, CW) \
  if (((ND) < 1) || ((HC) < 1) || ((HC) > (2 ** (CW)))) begin : g_param_check \
    $error("rst_seq_ctrl: illegal NUM_DOMAINS/HOLD_CYCLES/CNT_W combination"); \
  end
`endif

package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_IDLE    = 2'b10
  } state_t;

  // Stage index width: clog2 of the domain count, never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_hold_cnt.sv
`default_nettype none
// ============================================================================
// Module      : rst_hold_cnt
// Description : Hold counter for the reset sequencer. Counts enabled edges,
//               clears synchronously, and flags the terminal value
//               HOLD_CYCLES-1 combinationally from the registered count.
// Ports       : CLK      - clock, rising edge
//               RST      - asynchronous active-low reset
//               i_clr    - synchronous clear (priority over enable)
//               i_en     - count enable
//               o_term   - count == HOLD_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module rst_hold_cnt
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_term = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Reset release sequencer. After the synchronized domain reset
//               deasserts, releases NUM_DOMAINS downstream resets one at a
//               time (bit 0 first), HOLD_CYCLES edges apart. Reports
//               completion with a one-cycle done pulse and a busy flag. A
//               soft-reset request restarts the whole sequence.
// Ports       : CLK        - domain clock, rising edge
//               RST        - asynchronous active-low reset (pre-synchronized
//                            release)
//               SW_RST_REQ - synchronous soft-reset request, active-high level
//               DOM_RST    - sequenced active-low domain resets (registered)
//               RST_DONE   - one-cycle pulse when the last domain releases
//               BUSY       - high while any DOM_RST bit is low (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  output logic [NUM_DOMAINS-1:0] DOM_RST,
  output logic                   RST_DONE,
  output logic                   BUSY
);

  `RST_SEQ_PARAM_CHECK(NUM_DOMAINS, HOLD_CYCLES, CNT_W)

  localparam int                     c_IDX_W    = idx_width(NUM_DOMAINS);
  localparam logic [c_IDX_W-1:0]     c_LAST_IDX = c_IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] c_FIRST    = NUM_DOMAINS'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_DOMAINS-1:0] r_dom;
  logic [NUM_DOMAINS-1:0] w_dom_nxt;
  logic [c_IDX_W-1:0]     r_idx;
  logic [c_IDX_W-1:0]     w_idx_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   w_cnt_clr;
  logic                   w_cnt_en;
  logic                   w_cnt_term;

  rst_hold_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hold_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_term (w_cnt_term)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_ASSERT;
      r_dom   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_dom   <= w_dom_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dom_nxt   = r_dom;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b0;

    // Soft reset wins over any release that would land on the same edge,
    // and holding it keeps the counter parked at zero.
    if (SW_RST_REQ) begin
      w_state_nxt = ST_ASSERT;
      w_dom_nxt   = '0;
      w_idx_nxt   = '0;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_dom_nxt = '0;
          w_cnt_en  = 1'b1;
          if (w_cnt_term) begin
            w_dom_nxt = c_FIRST;
            w_cnt_clr = 1'b1;
            w_idx_nxt = c_IDX_W'(1);
            if (NUM_DOMAINS == 1) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RELEASE;
            end
          end
        end

        ST_RELEASE: begin
          w_cnt_en = 1'b1;
          if (w_cnt_term) begin
            w_cnt_clr = 1'b1;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (r_idx == c_IDX_W'(i)) begin
                w_dom_nxt[i] = 1'b1;
              end
            end
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == c_LAST_IDX) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end

        ST_IDLE: begin
          w_dom_nxt = '1;
        end

        default: begin
          w_state_nxt = ST_ASSERT;
          w_dom_nxt   = '0;
          w_idx_nxt   = '0;
          w_cnt_clr   = 1'b1;
        end
      endcase
    end

    // Busy is registered alongside the resets so it tracks them exactly.
    w_busy_nxt = ~(&w_dom_nxt);
  end

  assign DOM_RST  = r_dom;
  assign RST_DONE = r_done;
  assign BUSY     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Self-checking bench for rst_seq_ctrl. Default configuration
//               driven by a table of {soft-reset level, edge count, expected
//               outputs} records, plus hand-written sequences for the
//               asynchronous reset and the single-domain/single-cycle build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SW_RST_REQ;
  logic [2:0] DOM_RST;
  logic       RST_DONE;
  logic       BUSY;

  logic       RST1;
  logic       SW1;
  logic [0:0] DOM1;
  logic       DONE1;
  logic       BUSY1;

  always #5 CLK = ~CLK;

  rst_seq_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .DOM_RST    (DOM_RST),
    .RST_DONE   (RST_DONE),
    .BUSY       (BUSY)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS (1),
    .HOLD_CYCLES (1),
    .CNT_W       (1)
  ) dut1 (
    .CLK        (CLK),
    .RST        (RST1),
    .SW_RST_REQ (SW1),
    .DOM_RST    (DOM1),
    .RST_DONE   (DONE1),
    .BUSY       (BUSY1)
  );

  typedef struct {
    int         n;
    logic       sw;
    logic [2:0] dom;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  // Counts done pulses of the default instance, so a spurious pulse inside
  // a long table window is still caught.
  always @(negedge CLK) begin
    if (RST_DONE === 1'b1) done_cnt++;
  end

  task automatic add(input int n, input logic sw, input logic [2:0] dom,
                     input logic done, input logic busy);
    vec_t v;
    v.n    = n;
    v.sw   = sw;
    v.dom  = dom;
    v.done = done;
    v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk3(input string nm, input logic [2:0] dom, input logic done,
                      input logic busy);
    chk({nm, ".dom"},  32'(DOM_RST),  32'(dom));
    chk({nm, ".done"}, 32'(RST_DONE), 32'(done));
    chk({nm, ".busy"}, 32'(BUSY),     32'(busy));
  endtask

  initial begin
    RST        = 1'b0;
    SW_RST_REQ = 1'b0;
    RST1       = 1'b0;
    SW1        = 1'b0;

    // Power-up sequence: edges counted from the first edge after release.
    add(7, 1'b0, 3'b000, 1'b0, 1'b1);
    add(1, 1'b0, 3'b001, 1'b0, 1'b1);
    add(7, 1'b0, 3'b001, 1'b0, 1'b1);
    add(1, 1'b0, 3'b011, 1'b0, 1'b1);
    add(7, 1'b0, 3'b011, 1'b0, 1'b1);
    add(1, 1'b0, 3'b111, 1'b1, 1'b0);
    add(1, 1'b0, 3'b111, 1'b0, 1'b0);
    add(10, 1'b0, 3'b111, 1'b0, 1'b0);
    // One-cycle soft reset from idle.
    add(1, 1'b1, 3'b000, 1'b0, 1'b1);
    add(7, 1'b0, 3'b000, 1'b0, 1'b1);
    add(1, 1'b0, 3'b001, 1'b0, 1'b1);
    add(8, 1'b0, 3'b011, 1'b0, 1'b1);
    add(8, 1'b0, 3'b111, 1'b1, 1'b0);
    add(1, 1'b0, 3'b111, 1'b0, 1'b0);
    // Soft reset on the edge that would release domain 1.
    add(1, 1'b1, 3'b000, 1'b0, 1'b1);
    add(7, 1'b0, 3'b000, 1'b0, 1'b1);
    add(1, 1'b0, 3'b001, 1'b0, 1'b1);
    add(7, 1'b0, 3'b001, 1'b0, 1'b1);
    add(1, 1'b1, 3'b000, 1'b0, 1'b1);
    add(7, 1'b0, 3'b000, 1'b0, 1'b1);
    add(1, 1'b0, 3'b001, 1'b0, 1'b1);
    add(8, 1'b0, 3'b011, 1'b0, 1'b1);
    add(8, 1'b0, 3'b111, 1'b1, 1'b0);
    add(1, 1'b0, 3'b111, 1'b0, 1'b0);
    // Soft reset held for 20 cycles.
    add(10, 1'b1, 3'b000, 1'b0, 1'b1);
    add(10, 1'b1, 3'b000, 1'b0, 1'b1);
    add(7, 1'b0, 3'b000, 1'b0, 1'b1);
    add(1, 1'b0, 3'b001, 1'b0, 1'b1);
    add(8, 1'b0, 3'b011, 1'b0, 1'b1);
    add(8, 1'b0, 3'b111, 1'b1, 1'b0);
    add(1, 1'b0, 3'b111, 1'b0, 1'b0);

    // Reset values while RST is held low.
    step(3);
    chk3("reset", 3'b000, 1'b0, 1'b1);
    RST = 1'b1;

    foreach (tbl[i]) begin
      SW_RST_REQ = tbl[i].sw;
      step(tbl[i].n);
      chk3($sformatf("vec%0d", i), tbl[i].dom, tbl[i].done, tbl[i].busy);
    end
    SW_RST_REQ = 1'b0;

    // Asynchronous reset mid-sequence while DOM_RST = 011.
    SW_RST_REQ = 1'b1;
    step(1);
    SW_RST_REQ = 1'b0;
    step(16);
    chk3("async_pre", 3'b011, 1'b0, 1'b1);
    #2 RST = 1'b0;
    #1;
    chk3("async_imm", 3'b000, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    chk3("async_hold", 3'b000, 1'b0, 1'b1);
    RST = 1'b1;
    step(7);
    chk3("async_r7", 3'b000, 1'b0, 1'b1);
    step(1);
    chk3("async_r8", 3'b001, 1'b0, 1'b1);
    step(16);
    chk3("async_r24", 3'b111, 1'b1, 1'b0);
    step(1);
    chk3("async_r25", 3'b111, 1'b0, 1'b0);

    chk("done_pulses", 32'(done_cnt), 32'd5);

    // Single domain, single hold cycle.
    chk("d1_reset.dom",  32'(DOM1),  32'd0);
    chk("d1_reset.done", 32'(DONE1), 32'd0);
    chk("d1_reset.busy", 32'(BUSY1), 32'd1);
    RST1 = 1'b1;
    step(1);
    chk("d1_e1.dom",  32'(DOM1),  32'd1);
    chk("d1_e1.done", 32'(DONE1), 32'd1);
    chk("d1_e1.busy", 32'(BUSY1), 32'd0);
    step(1);
    chk("d1_e2.dom",  32'(DOM1),  32'd1);
    chk("d1_e2.done", 32'(DONE1), 32'd0);
    chk("d1_e2.busy", 32'(BUSY1), 32'd0);
    SW1 = 1'b1;
    step(1);
    chk("d1_sw.dom",  32'(DOM1),  32'd0);
    chk("d1_sw.busy", 32'(BUSY1), 32'd1);
    SW1 = 1'b0;
    step(1);
    chk("d1_rel.dom",  32'(DOM1),  32'd1);
    chk("d1_rel.done", 32'(DONE1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
